gpu_raster_engine: RTL
======================

# gpu_raster_engine

Parametrised command-driven rasteriser sitting between the host command port and the frame buffer inside `gpu_top`. It is the successor of the single-line drawer. It buffers incoming commands in a FIFO and supports line, filled-rectangle, clear and point opcodes. It applies back-pressure on both sides and emits at most one pixel write per clock.

## Interface
- `FB_WIDTH`, 320, frame-buffer width in pixels.
- `FB_HEIGHT`, 240, frame-buffer height in pixels.
- `COORD_W`, 9, coordinate width (unsigned).
- `COLOR_W`, 8, pixel colour width.
- `FIFO_DEPTH`, 4, command FIFO entries (power of two, ≥2).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_data`  in  CMD_W = 4·COORD_W+COLOR_W+4  command word {op[1:0], x0, y0, x1, y1, rsvd[1:0], color} (48 bits at defaults).
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `fb_we`  out  1  pixel write valid.
- `fb_addr`  out  ADDR_W = $clog2(FB_WIDTH·FB_HEIGHT)  pixel address, y·FB_WIDTH+x.
- `fb_data`  out  COLOR_W  pixel colour.
- `fb_ready`  in  1  frame buffer accepts write.
- `busy`  out  1  FIFO non-empty or engine not IDLE.

## Operation
- Opcodes:
  - 00 LINE: Bresenham from (x0,y0) to (x1,y1), all octants, both endpoints inclusive, max(|dx|,|dy|)+1 pixels.
  - 01 RECT: filled; corners normalised to min/max; row-major order, top row first, left to right.
  - 10 CLEAR: RECT (0,0)–(FB_WIDTH-1,FB_HEIGHT-1); coordinates ignored.
  - 11 POINT: the single pixel (x0,y0).
- `rsvd` bits are ignored.
- Push: on `cmd_valid && cmd_ready`. No bypass; a full FIFO refuses pushes even when a pop happens in the same cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head and go to SETUP.
  - SETUP: compute dx, dy, sx, sy, err (or rect bounds); go to DRAW.
  - DRAW: emit pixels; after the last pixel transfers, go to IDLE.
- Pixel transfer occurs on `fb_we && fb_ready`. While `fb_we && !fb_ready`, `fb_addr`/`fb_data` are held and the stepper is stalled. `fb_we` never drops without a transfer.
- Arithmetic: dx/dy/err are COORD_W+2 bits signed. Address multiply is done in ADDR_W bits.

## Timing
- Reset values: `cmd_ready`=1 (deasserted only while `reset` is low), `fb_we`=0, `fb_addr`=0, `fb_data`=0, `busy`=0, FIFO empty, state IDLE.
- Latency into an idle engine with an empty FIFO:
  - push at edge N;
  - pop/IDLE→SETUP at edge N+1;
  - SETUP→DRAW at N+2, with `fb_we`=1 after N+2 (first pixel available 2 cycles after acceptance).
- Throughput: one pixel per cycle with `fb_ready`=1.
- Command turnaround: after the last transfer, IDLE→SETUP→DRAW takes 2 bubble cycles with `fb_we`=0.
- `busy` falls in the cycle after the final pixel transfer when the FIFO is empty.
- Reset asserted mid-draw: async clear of FIFO and FSM. `fb_we` drops immediately and the partial command is discarded.

## Configuration
- `GPU_RASTER_CLIP_EN` defined: pixels with x≥FB_WIDTH or y≥FB_HEIGHT are skipped. The stepper advances without asserting `fb_we` and spends 1 cycle per clipped pixel.
- Not defined: every pixel is written, with the address truncated to ADDR_W bits.

## Test plan
- LINE (0,0)→(5,5), color 0xFF → 6 writes, addrs 0,321,642,963,1284,1605, data 0xFF; first `fb_we` 2 cycles after acceptance.
- LINE (10,3)→(7,3), color 0x11 → addrs 970,969,968,967; then RECT corners (3,2),(2,1), color 0x5A → addrs 322,323,642,643, with 2 idle cycles between the two commands.
- Back-pressure: `fb_ready`=0 for 3 cycles during the (0,0)→(5,5) line → address/data held stable, still exactly 6 writes in order.
- FIFO full: `fb_ready`=0 and 6 POINT commands offered → `cmd_ready` drops after 5 accepts (1 in engine + 4 in FIFO). The 6th is accepted the cycle after the first pop; all 6 are eventually written.
- Clip: LINE (318,0)→(321,0) → with `GPU_RASTER_CLIP_EN`, addrs 318,319 only; without, 4 writes 318–321.
- Reset low mid-CLEAR → `fb_we`=0 and `busy`=0 asynchronously, `cmd_ready`=1 after release, and a following POINT (1,1) writes addr 321.

Source files
------------

// File: rtl/gpu_raster_engine.sv
// gpu_raster_engine
//   Command-driven rasteriser between the host command port and the frame
//   buffer. Commands are queued in a FIFO, then drawn one at a time as LINE
//   (Bresenham, all octants), filled RECT, CLEAR (whole frame) or POINT.
//   At most one pixel write is issued per clock, with back-pressure on both
//   the command side and the frame-buffer side.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   cmd_data   command word {op[1:0], x0, y0, x1, y1, rsvd[1:0], color}
//   cmd_valid  command offered
//   cmd_ready  FIFO can accept a command
//   fb_we      pixel write valid
//   fb_addr    pixel address y*FB_WIDTH + x
//   fb_data    pixel colour
//   fb_ready   frame buffer accepts the write
//   busy       FIFO non-empty or a command in progress
// Build option:
//   GPU_RASTER_CLIP_EN  skip pixels with x >= FB_WIDTH or y >= FB_HEIGHT
module gpu_raster_engine #(
   parameter int unsigned FB_WIDTH   = 320,
   parameter int unsigned FB_HEIGHT  = 240,
   parameter int unsigned COORD_W    = 9,
   parameter int unsigned COLOR_W    = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned CMD_W     = 4*COORD_W + COLOR_W + 4,
   localparam int unsigned ADDR_W    = $clog2(FB_WIDTH*FB_HEIGHT)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CMD_W-1:0]   cmd_data,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   output logic               fb_we,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_data,
   input  logic               fb_ready,
   output logic               busy
);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned SW     = COORD_W + 2;
   localparam int unsigned FIFO_W = CMD_W - 2;

   localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
   localparam logic [COORD_W-1:0] CLR_X_HI = COORD_W'(FB_WIDTH - 1);
   localparam logic [COORD_W-1:0] CLR_Y_HI = COORD_W'(FB_HEIGHT - 1);
   localparam logic [PTR_W:0]     PTR_ONE  = (PTR_W+1)'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_DRAW} state_e;
   typedef enum logic [1:0] {
      OP_LINE  = 2'b00,
      OP_RECT  = 2'b01,
      OP_CLEAR = 2'b10,
      OP_POINT = 2'b11
   } op_e;

   state_e state_q, state_d;

   // ---------------- command FIFO (rsvd bits are dropped on entry) ----------
   logic [FIFO_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              fifo_empty, fifo_full, push, pop;
   logic [FIFO_W-1:0] fifo_head;
   logic              rsvd_unused;

   assign rsvd_unused = ^cmd_data[COLOR_W+1:COLOR_W];
   assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
   assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   // Full refuses a push even if a pop happens in the same cycle.
   assign cmd_ready   = reset & ~fifo_full;
   assign push        = cmd_valid & cmd_ready;
   assign pop         = (state_q == ST_IDLE) & ~fifo_empty;
   assign fifo_head   = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
   assign rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {cmd_data[CMD_W-1:COLOR_W+2],
                                             cmd_data[COLOR_W-1:0]};
      end
   end

   // ---------------- current command fields ---------------------------------
   logic [FIFO_W-1:0]  cmd_q, cmd_d;
   op_e                c_op;
   logic [COORD_W-1:0] c_x0, c_y0, c_x1, c_y1;
   logic [COLOR_W-1:0] c_color;

   assign c_op    = op_e'(cmd_q[FIFO_W-1 -: 2]);
   assign c_x0    = cmd_q[FIFO_W-3 -: COORD_W];
   assign c_y0    = cmd_q[FIFO_W-3-COORD_W -: COORD_W];
   assign c_x1    = cmd_q[FIFO_W-3-2*COORD_W -: COORD_W];
   assign c_y1    = cmd_q[FIFO_W-3-3*COORD_W -: COORD_W];
   assign c_color = cmd_q[COLOR_W-1:0];

   // ---------------- setup arithmetic ---------------------------------------
   logic signed [SW-1:0] diff_x, diff_y, abs_dx, neg_dy;
   logic [COORD_W-1:0]   rect_x_lo, rect_x_hi, rect_y_lo, rect_y_hi;

   assign diff_x    = signed'({2'b00, c_x1}) - signed'({2'b00, c_x0});
   assign diff_y    = signed'({2'b00, c_y1}) - signed'({2'b00, c_y0});
   assign abs_dx    = diff_x[SW-1] ? -diff_x : diff_x;
   assign neg_dy    = diff_y[SW-1] ? diff_y : -diff_y;
   assign rect_x_lo = (c_x0 < c_x1) ? c_x0 : c_x1;
   assign rect_x_hi = (c_x0 < c_x1) ? c_x1 : c_x0;
   assign rect_y_lo = (c_y0 < c_y1) ? c_y0 : c_y1;
   assign rect_y_hi = (c_y0 < c_y1) ? c_y1 : c_y0;

   // ---------------- stepper state ------------------------------------------
   logic [COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [COORD_W-1:0]   start_x_q, start_x_d, end_x_q, end_x_d, end_y_q, end_y_d;
   logic signed [SW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
   logic                 is_line_q, is_line_d;
   logic                 fb_we_q, fb_we_d;
   logic [ADDR_W-1:0]    fb_addr_q, fb_addr_d;
   logic [COLOR_W-1:0]   fb_data_q, fb_data_d;

   logic signed [SW:0]   e2, dx_w, dy_w;
   logic signed [SW-1:0] err_n;
   logic [COORD_W-1:0]   nx, ny;
   logic                 advance, at_last, pix_in_range, load_pix;
   logic [ADDR_W-1:0]    pix_addr;

   assign e2   = {err_q, 1'b0};
   assign dx_w = {dx_q[SW-1], dx_q};
   assign dy_w = {dy_q[SW-1], dy_q};

   // A presented pixel moves on when transferred, or at once when clipped.
   assign advance = (state_q == ST_DRAW) & (~fb_we_q | fb_ready);
   assign at_last = (cur_x_q == end_x_q) & (cur_y_q == end_y_q);

   // Next pixel: first pixel in SETUP, successor of the current one in DRAW.
   always_comb begin
      nx    = cur_x_q;
      ny    = cur_y_q;
      err_n = err_q;
      if (state_q == ST_SETUP) begin
         unique case (c_op)
            OP_LINE, OP_POINT: begin nx = c_x0;      ny = c_y0;      end
            OP_RECT:           begin nx = rect_x_lo; ny = rect_y_lo; end
            OP_CLEAR:          begin nx = '0;        ny = '0;        end
         endcase
      end else if (is_line_q) begin
         if (e2 >= dy_w) begin
            err_n = err_n + dy_q;
            nx    = sx_neg_q ? cur_x_q - ONE : cur_x_q + ONE;
         end
         if (e2 <= dx_w) begin
            err_n = err_n + dx_q;
            ny    = sy_neg_q ? cur_y_q - ONE : cur_y_q + ONE;
         end
      end else if (cur_x_q == end_x_q) begin
         nx = start_x_q;
         ny = cur_y_q + ONE;
      end else begin
         nx = cur_x_q + ONE;
      end
   end

`ifdef GPU_RASTER_CLIP_EN
   localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(FB_WIDTH);
   localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(FB_HEIGHT);
   assign pix_in_range = ({1'b0, nx} < X_LIM) & ({1'b0, ny} < Y_LIM);
`else
   assign pix_in_range = 1'b1;
`endif

   assign pix_addr = ADDR_W'(ny) * ADDR_W'(FB_WIDTH) + ADDR_W'(nx);

   // ---------------- FSM: state register ------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (!fifo_empty) state_d = ST_SETUP;
         ST_SETUP: state_d = ST_DRAW;
         ST_DRAW:  if (advance && at_last) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / datapath --------------------------------
   always_comb begin
      cmd_d     = cmd_q;
      cur_x_d   = cur_x_q;
      cur_y_d   = cur_y_q;
      start_x_d = start_x_q;
      end_x_d   = end_x_q;
      end_y_d   = end_y_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      err_d     = err_q;
      sx_neg_d  = sx_neg_q;
      sy_neg_d  = sy_neg_q;
      is_line_d = is_line_q;
      fb_we_d   = fb_we_q;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      load_pix  = 1'b0;

      if (pop) cmd_d = fifo_head;

      if (state_q == ST_SETUP) begin
         is_line_d = (c_op == OP_LINE);
         dx_d      = abs_dx;
         dy_d      = neg_dy;
         err_d     = abs_dx + neg_dy;
         sx_neg_d  = diff_x[SW-1];
         sy_neg_d  = diff_y[SW-1];
         start_x_d = nx;
         unique case (c_op)
            OP_LINE:  begin end_x_d = c_x1;      end_y_d = c_y1;      end
            OP_RECT:  begin end_x_d = rect_x_hi; end_y_d = rect_y_hi; end
            OP_CLEAR: begin end_x_d = CLR_X_HI;  end_y_d = CLR_Y_HI;  end
            OP_POINT: begin end_x_d = c_x0;      end_y_d = c_y0;      end
         endcase
         load_pix = 1'b1;
      end else if (advance) begin
         if (at_last) begin
            fb_we_d = 1'b0;
         end else begin
            err_d    = err_n;
            load_pix = 1'b1;
         end
      end

      if (load_pix) begin
         cur_x_d   = nx;
         cur_y_d   = ny;
         fb_we_d   = pix_in_range;
         fb_addr_d = pix_addr;
         fb_data_d = c_color;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cmd_q     <= '0;
         cur_x_q   <= '0;
         cur_y_q   <= '0;
         start_x_q <= '0;
         end_x_q   <= '0;
         end_y_q   <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
         err_q     <= '0;
         sx_neg_q  <= 1'b0;
         sy_neg_q  <= 1'b0;
         is_line_q <= 1'b0;
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cmd_q     <= cmd_d;
         cur_x_q   <= cur_x_d;
         cur_y_q   <= cur_y_d;
         start_x_q <= start_x_d;
         end_x_q   <= end_x_d;
         end_y_q   <= end_y_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         err_q     <= err_d;
         sx_neg_q  <= sx_neg_d;
         sy_neg_q  <= sy_neg_d;
         is_line_q <= is_line_d;
         fb_we_q   <= fb_we_d;
         fb_addr_q <= fb_addr_d;
         fb_data_q <= fb_data_d;
      end
   end

   assign fb_we   = fb_we_q;
   assign fb_addr = fb_addr_q;
   assign fb_data = fb_data_q;
   assign busy    = ~fifo_empty | (state_q != ST_IDLE);

endmodule
